branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor and mispredict resolver. Bridges fetch, where it produces the prediction, and execute, where it consumes the resolved outcome.
- Fetch side: a combinational lookup of PC_F gives Predict_Taken_F and Predict_Target_F; both travel down the pipeline to execute as Predict_Taken_E and Predict_Target_E.
- Execute side: compares the prediction against the actual outcome, updates the table, flags mispredicts and supplies the redirect PC to the hazard unit.
- Table: direct-mapped, combined BTB and 2-bit saturating-counter BHT.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64). Index = PC[INDEX_BITS+1:2]; tag = PC[31:INDEX_BITS+2].

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- PC_F  in  32  fetch-stage PC
- Predict_Taken_F  out  1  predicted taken for PC_F
- Predict_Target_F  out  32  predicted target for PC_F
- Stall_E  in  1  execute stage held; suppresses update and statistics
- Branch_En_E  in  1  execute instruction is a conditional branch
- Jump_En_E  in  1  execute instruction is JAL/JALR
- Branch_Taken_E  in  1  resolved branch condition
- PC_E  in  32  execute-stage PC
- PC_Plus_4_E  in  32  execute-stage PC+4
- Target_E  in  32  computed branch/jump target
- Predict_Taken_E  in  1  prediction carried from fetch
- Predict_Target_E  in  32  predicted target carried from fetch
- Mispredict_E  out  1  redirect required
- Redirect_PC_E  out  32  correct next PC
- Branch_Count  out  32  resolved branches + jumps
- Mispredict_Count  out  32  mispredicts

Behaviour:
- Entry contents: valid, tag, target[31:0], ctr[1:0]. Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Reset (asynchronous, RST_N=0):
  - all entries: valid=0, ctr=01, tag=0, target=0;
  - Branch_Count=0, Mispredict_Count=0.
  - Combinational outputs follow their definitions; with tables cleared, Predict_Taken_F=0.
- Lookup (combinational, zero latency):
  - hit = valid && tag match on PC_F's index.
  - Predict_Taken_F = hit && ctr[1].
  - Predict_Target_F = hit ? target : PC_F+4.
- Resolution (combinational):
  - taken_act = Jump_En_E | (Branch_En_E & Branch_Taken_E).
  - Redirect_PC_E = taken_act ? Target_E : PC_Plus_4_E.
  - Mispredict_E = (taken_act != Predict_Taken_E) | (taken_act & Predict_Taken_E & Target_E != Predict_Target_E).
  - A non-branch predicted taken (stale or aliased entry) gives Mispredict_E=1, Redirect_PC_E=PC_Plus_4_E.
- Mispredict_E is valid regardless of Stall_E. A flushed execute slot has Branch_En_E=Jump_En_E=0 and Predict_Taken_E is don't-care; the hazard unit gates Mispredict_E with its own flush.
- Update (posedge CLK, only when Stall_E=0), at index/tag of PC_E:
  - Jump_En_E: write valid=1, tag, target=Target_E, ctr=11.
  - Branch taken, miss: allocate valid=1, tag, target=Target_E, ctr=10.
  - Branch taken, hit: target=Target_E; ctr saturating increment (11 stays 11).
  - Branch not taken, hit: ctr saturating decrement (00 stays 00); target unchanged.
  - Branch not taken, miss: no write.
  - Neither branch nor jump, but Predict_Taken_E=1 and hit on PC_E: clear valid.
  - Otherwise: no write.
- Statistics: Branch_Count +1 on any branch/jump; Mispredict_Count +1 when Mispredict_E and (Branch_En_E|Jump_En_E|Predict_Taken_E). Both saturate at 0xFFFF_FFFF; both only advance when Stall_E=0.
- Same-cycle lookup and update to one index: lookup returns the pre-update entry; the new value is visible the next cycle.
- Reset asserted mid-operation clears everything immediately; no partial update completes.
- Stall_E held for N cycles: exactly one update, applied on the first cycle after Stall_E falls.

Decomposition:
- Package definitions:
  - bp_entry_t struct (valid, tag, target, ctr);
  - counter constants CTR_SNT/WNT/WT/ST;
  - function sat_update(ctr, taken).
- Sub-module bp_table: storage, asynchronous-reset clear, one combinational read port and one synchronous write port. branch_predictor holds resolution, update decision and statistics.

Test Plan:
- Reset, then PC_F=0x100 -> Predict_Taken_F=0, Predict_Target_F=0x104; both counters 0.
- Branch at PC_E=0x100, taken, Target_E=0x80, Predict_Taken_E=0 -> Mispredict_E=1, Redirect_PC_E=0x80. Next cycle PC_F=0x100 -> Predict_Taken_F=1, target 0x80, ctr=10. Counts 1/1.
- Same branch not taken twice (predicted 1, then 0) -> ctr 10 -> 01 -> 00. First resolution Mispredict_E=1, Redirect_PC_E=0x104; second resolution Mispredict_E=0. Four further taken outcomes saturate ctr at 11.
- JAL at PC_E=0x200, Target_E=0x400, predicted taken with Predict_Target_E=0x300 -> Mispredict_E=1, Redirect_PC_E=0x400. Entry target rewritten to 0x400, ctr=11.
- Aliasing: PC 0x100 and 0x200 share index 0 under different tags. Update 0x200 as a jump, then lookup 0x100 -> miss, 0x104. Simultaneous update and lookup of 0x200 in one cycle -> old value returned.
- Stall_E=1 for 3 cycles with a taken branch -> one ctr step, Branch_Count +1. RST_N pulsed low mid-stream -> all entries cleared, counters 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor.
//   bp_entry_t  - one combined BTB/BHT entry (valid, tag, target, 2-bit counter)
//   CTR_*       - 2-bit saturating counter encodings
//   sat_update  - saturating counter step toward the resolved direction
package branch_predictor_pkg;

  localparam int DEF_INDEX_BITS = 6;
  // The tag field is sized for the smallest legal index.
  // Bits above 32-INDEX_BITS-2 are always zero and are trimmed in synthesis.
  localparam int TAG_W_MAX = 30;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [31:0]          target;
    ctr_t                 ctr;
  } bp_entry_t;

  function automatic ctr_t sat_update(ctr_t ctr, logic taken);
    ctr_t r;
    r = ctr;
    if (taken && ctr != CTR_ST) r = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT) r = ctr - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle for the branch predictor.
//   master : the pipeline (drives PC_F, execute resolution info, Stall_E)
//   slave  : the predictor (drives prediction, redirect, statistics)
interface branch_predictor_if;
  // fetch side
  logic        PC_F_unused_guard;
  logic [31:0] PC_F;
  logic        Predict_Taken_F;
  logic [31:0] Predict_Target_F;
  // execute side
  logic        Stall_E;
  logic        Branch_En_E;
  logic        Jump_En_E;
  logic        Branch_Taken_E;
  logic [31:0] PC_E;
  logic [31:0] PC_Plus_4_E;
  logic [31:0] Target_E;
  logic        Predict_Taken_E;
  logic [31:0] Predict_Target_E;
  logic        Mispredict_E;
  logic [31:0] Redirect_PC_E;
  // statistics
  logic [31:0] Branch_Count;
  logic [31:0] Mispredict_Count;

  modport master (
    output PC_F, Stall_E, Branch_En_E, Jump_En_E, Branch_Taken_E, PC_E,
           PC_Plus_4_E, Target_E, Predict_Taken_E, Predict_Target_E,
    input  Predict_Taken_F, Predict_Target_F, Mispredict_E, Redirect_PC_E,
           Branch_Count, Mispredict_Count
  );

  modport slave (
    input  PC_F, Stall_E, Branch_En_E, Jump_En_E, Branch_Taken_E, PC_E,
           PC_Plus_4_E, Target_E, Predict_Taken_E, Predict_Target_E,
    output Predict_Taken_F, Predict_Target_F, Mispredict_E, Redirect_PC_E,
           Branch_Count, Mispredict_Count
  );
endinterface

// File: rtl/branch_predictor_bp_table.sv
// Direct-mapped predictor storage.
//   clk, rst_n  : clock, async active-low reset (clears every entry)
//   rd_idx_i/rd_ent_o : NUM_RD combinational read ports
//   we_i, wr_idx_i, wr_ent_i : one synchronous write port
// A read of an index being written in the same cycle returns the old entry.
module bp_table
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int NUM_RD     = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_RD-1:0][INDEX_BITS-1:0]   rd_idx_i,
  output bp_entry_t [NUM_RD-1:0]              rd_ent_o,
  input  logic                                we_i,
  input  logic [INDEX_BITS-1:0]               wr_idx_i,
  input  bp_entry_t                           wr_ent_i
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam bp_entry_t RST_ENT = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

  bp_entry_t mem_q [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= RST_ENT;
    end else if (we_i) begin
      mem_q[wr_idx_i] <= wr_ent_i;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_ent_o[p] = mem_q[rd_idx_i[p]];
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor with mispredict resolution.
//   CLK, RST_N : clock, async active-low reset
//   bp (slave) : fetch lookup (PC_F -> Predict_Taken_F/Predict_Target_F),
//                execute resolution (Mispredict_E, Redirect_PC_E),
//                table update and saturating statistics counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic             CLK,
  input  logic             RST_N,
  branch_predictor_if.slave bp
);
  localparam int RD_F = 0;
  localparam int RD_E = 1;

  logic [1:0][INDEX_BITS-1:0] rd_idx;
  bp_entry_t [1:0]            rd_ent;
  logic [TAG_W_MAX-1:0]       tag_f, tag_e;
  logic                       hit_f, hit_e;

  logic      we;
  bp_entry_t wr_ent;

  logic        taken_act;
  logic        br_or_jmp;
  logic [31:0] bcnt_q, bcnt_d;
  logic [31:0] mcnt_q, mcnt_d;

  // ---- lookup (fetch and execute share the table via two read ports)
  assign rd_idx[RD_F] = bp.PC_F[INDEX_BITS+1:2];
  assign rd_idx[RD_E] = bp.PC_E[INDEX_BITS+1:2];
  assign tag_f = TAG_W_MAX'(bp.PC_F >> (INDEX_BITS + 2));
  assign tag_e = TAG_W_MAX'(bp.PC_E >> (INDEX_BITS + 2));
  assign hit_f = rd_ent[RD_F].valid && (rd_ent[RD_F].tag == tag_f);
  assign hit_e = rd_ent[RD_E].valid && (rd_ent[RD_E].tag == tag_e);

  assign bp.Predict_Taken_F  = hit_f && rd_ent[RD_F].ctr[1];
  assign bp.Predict_Target_F = hit_f ? rd_ent[RD_F].target : bp.PC_F + 32'd4;

  // ---- resolution
  assign br_or_jmp = bp.Branch_En_E | bp.Jump_En_E;
  assign taken_act = bp.Jump_En_E | (bp.Branch_En_E & bp.Branch_Taken_E);
  assign bp.Redirect_PC_E = taken_act ? bp.Target_E : bp.PC_Plus_4_E;
  assign bp.Mispredict_E  = (taken_act != bp.Predict_Taken_E) |
                            (taken_act & bp.Predict_Taken_E &
                             (bp.Target_E != bp.Predict_Target_E));

  // ---- update decision
  always_comb begin
    we     = 1'b0;
    wr_ent = rd_ent[RD_E];
    if (!bp.Stall_E) begin
      if (bp.Jump_En_E) begin
        we     = 1'b1;
        wr_ent = '{valid: 1'b1, tag: tag_e, target: bp.Target_E, ctr: CTR_ST};
      end else if (bp.Branch_En_E) begin
        if (bp.Branch_Taken_E) begin
          we     = 1'b1;
          wr_ent = '{valid: 1'b1, tag: tag_e, target: bp.Target_E,
                     ctr: hit_e ? sat_update(rd_ent[RD_E].ctr, 1'b1) : CTR_WT};
        end else if (hit_e) begin
          we         = 1'b1;
          wr_ent.ctr = sat_update(rd_ent[RD_E].ctr, 1'b0);
        end
      end else if (bp.Predict_Taken_E && hit_e) begin
        // Stale/aliased entry predicted taken on a non-branch: drop it.
        we           = 1'b1;
        wr_ent.valid = 1'b0;
      end
    end
  end

  bp_table #(.INDEX_BITS(INDEX_BITS), .NUM_RD(2)) u_table (
    .clk      (CLK),
    .rst_n    (RST_N),
    .rd_idx_i (rd_idx),
    .rd_ent_o (rd_ent),
    .we_i     (we),
    .wr_idx_i (rd_idx[RD_E]),
    .wr_ent_i (wr_ent)
  );

  // ---- statistics (saturating)
  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (!bp.Stall_E) begin
      if (br_or_jmp && bcnt_q != '1) bcnt_d = bcnt_q + 32'd1;
      if (bp.Mispredict_E && (br_or_jmp || bp.Predict_Taken_E) && mcnt_q != '1)
        mcnt_d = mcnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign bp.Branch_Count     = bcnt_q;
  assign bp.Mispredict_Count = mcnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor.
module tb_branch_predictor;
  logic CLK = 1'b0;
  logic RST_N;
  int   checks = 0;
  int   failures = 0;

  branch_predictor_if bp ();

  branch_predictor #(.INDEX_BITS(6)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bp    (bp.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bp.Stall_E          = 1'b0;
    bp.Branch_En_E      = 1'b0;
    bp.Jump_En_E        = 1'b0;
    bp.Branch_Taken_E   = 1'b0;
    bp.PC_E             = 32'h0;
    bp.PC_Plus_4_E      = 32'h4;
    bp.Target_E         = 32'h0;
    bp.Predict_Taken_E  = 1'b0;
    bp.Predict_Target_E = 32'h4;
  endtask

  task automatic set_e(input logic br, input logic jmp, input logic tk,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
    bp.Branch_En_E      = br;
    bp.Jump_En_E        = jmp;
    bp.Branch_Taken_E   = tk;
    bp.PC_E             = pc;
    bp.PC_Plus_4_E      = pc + 32'd4;
    bp.Target_E         = tgt;
    bp.Predict_Taken_E  = pt;
    bp.Predict_Target_E = ptgt;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic pt, input logic [31:0] tgt);
    bp.PC_F = pc;
    #1;
    chk({tag, "_pt"}, {31'b0, bp.Predict_Taken_F}, {31'b0, pt});
    chk({tag, "_tgt"}, bp.Predict_Target_F, tgt);
  endtask

  task automatic res(input string tag, input logic mp, input logic [31:0] rpc);
    #1;
    chk({tag, "_mp"}, {31'b0, bp.Mispredict_E}, {31'b0, mp});
    chk({tag, "_rpc"}, bp.Redirect_PC_E, rpc);
  endtask

  task automatic cnt(input string tag, input logic [31:0] b, input logic [31:0] m);
    chk({tag, "_bcnt"}, bp.Branch_Count, b);
    chk({tag, "_mcnt"}, bp.Mispredict_Count, m);
  endtask

  initial begin
    RST_N = 1'b0;
    bp.PC_F = 32'h100;
    idle();
    #8;
    look("rst", 32'h100, 1'b0, 32'h104);
    cnt("rst", 0, 0);
    #2 RST_N = 1'b1;
    step();

    // first taken branch at 0x100 allocates ctr=10; same-cycle lookup sees old
    set_e(1, 0, 1, 32'h100, 32'h80, 0, 32'h104);
    res("br1", 1'b1, 32'h80);
    look("br1_same", 32'h100, 1'b0, 32'h104);
    step(); idle();
    look("br1_after", 32'h100, 1'b1, 32'h80);
    cnt("br1", 1, 1);

    // not taken, predicted taken: 10 -> 01
    set_e(1, 0, 0, 32'h100, 32'h80, 1, 32'h80);
    res("nt1", 1'b1, 32'h104);
    step(); idle();
    look("nt1", 32'h100, 1'b0, 32'h80);
    cnt("nt1", 2, 2);

    // not taken, predicted not taken: 01 -> 00
    set_e(1, 0, 0, 32'h100, 32'h80, 0, 32'h104);
    res("nt2", 1'b0, 32'h104);
    step(); idle();
    look("nt2", 32'h100, 1'b0, 32'h80);
    cnt("nt2", 3, 2);

    // four taken: 00 -> 01 -> 10 -> 11 -> 11
    set_e(1, 0, 1, 32'h100, 32'h80, 0, 32'h104);
    res("t1", 1'b1, 32'h80);
    step(); idle();
    look("t1", 32'h100, 1'b0, 32'h80);
    set_e(1, 0, 1, 32'h100, 32'h80, 0, 32'h104);
    step(); idle();
    look("t2", 32'h100, 1'b1, 32'h80);
    set_e(1, 0, 1, 32'h100, 32'h80, 1, 32'h80);
    res("t3", 1'b0, 32'h80);
    step(); idle();
    set_e(1, 0, 1, 32'h100, 32'h80, 1, 32'h80);
    step(); idle();
    cnt("t4", 7, 4);
    // one not-taken from a saturated 11 still predicts taken
    set_e(1, 0, 0, 32'h100, 32'h80, 1, 32'h80);
    res("sat", 1'b1, 32'h104);
    step(); idle();
    look("sat", 32'h100, 1'b1, 32'h80);
    cnt("sat", 8, 5);

    // JAL at 0x200 aliases index 0; same-cycle lookup of 0x200 misses
    set_e(0, 1, 0, 32'h200, 32'h400, 1, 32'h300);
    res("jal", 1'b1, 32'h400);
    look("jal_same", 32'h200, 1'b0, 32'h204);
    step(); idle();
    look("jal_after", 32'h200, 1'b1, 32'h400);
    look("alias", 32'h100, 1'b0, 32'h104);
    cnt("jal", 9, 6);

    // retarget the jump; lookup in the update cycle returns the old target
    set_e(0, 1, 0, 32'h200, 32'h500, 1, 32'h400);
    res("jal2", 1'b1, 32'h500);
    look("jal2_same", 32'h200, 1'b1, 32'h400);
    step(); idle();
    look("jal2_after", 32'h200, 1'b1, 32'h500);
    cnt("jal2", 10, 7);

    // non-branch predicted taken on a hit: mispredict, entry invalidated
    set_e(0, 0, 0, 32'h200, 32'h0, 1, 32'h500);
    res("stale", 1'b1, 32'h204);
    step(); idle();
    look("stale", 32'h200, 1'b0, 32'h204);
    cnt("stale", 10, 8);

    // stalled taken branch at 0x104 (index 1): no update until stall drops
    set_e(1, 0, 1, 32'h104, 32'h40, 0, 32'h108);
    bp.Stall_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      res("stall", 1'b1, 32'h40);
      step();
      look("stall", 32'h104, 1'b0, 32'h108);
      cnt("stall", 10, 8);
    end
    bp.Stall_E = 1'b0;
    step(); idle();
    look("unstall", 32'h104, 1'b1, 32'h40);
    cnt("unstall", 11, 9);
    // exactly one step applied: ctr 10 -> 01 on a not-taken
    set_e(1, 0, 0, 32'h104, 32'h40, 1, 32'h40);
    step(); idle();
    look("one_step", 32'h104, 1'b0, 32'h40);
    cnt("one_step", 12, 10);

    // reset mid-stream with a pending taken branch
    set_e(1, 0, 1, 32'h104, 32'h40, 0, 32'h108);
    #2 RST_N = 1'b0;
    look("mrst", 32'h104, 1'b0, 32'h108);
    cnt("mrst", 0, 0);
    step();
    look("mrst_hold", 32'h104, 1'b0, 32'h108);
    cnt("mrst_hold", 0, 0);
    idle();
    RST_N = 1'b1;
    step();
    look("post_rst", 32'h200, 1'b0, 32'h204);
    look("post_rst1", 32'h100, 1'b0, 32'h104);
    cnt("post_rst", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
